// File: rtl/thresh_frame_ctrl.sv
// thresh_frame_ctrl: frame sequencer, C latch and image-port arbiter for the 3x3 adaptive-threshold engine
module thresh_frame_ctrl #(
  parameter int WIDTH_BITS     = 8,
  parameter int HEIGHT_BITS    = 8,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int CNT_BITS       = 20,
  parameter int C_INIT         = 5
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   start,
  input  logic                   auto_mode,
  input  logic                   c_up,
  input  logic                   c_down,
  output logic                   eng_rst_n,
  output logic                   eng_processing,
  input  logic                   eng_finished,
  output logic [4:0]             eng_C,
  input  logic [WIDTH_BITS-1:0]  eng_col,
  input  logic [HEIGHT_BITS-1:0] eng_row,
  input  logic [WIDTH_BITS-1:0]  disp_col,
  input  logic [HEIGHT_BITS-1:0] disp_row,
  output logic [WIDTH_BITS-1:0]  img_col,
  output logic [HEIGHT_BITS-1:0] img_row,
  output logic                   disp_stall,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [4:0]             c_now,
  output logic [CNT_BITS-1:0]    frame_cycles
);
  typedef enum logic [2:0] {IDLE, ERST, RUN, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, frame_cycles_q, frame_cycles_d;
  logic [4:0] c_now_q, c_now_d, eng_c_q, eng_c_d;
  logic eng_rst_n_q, eng_rst_n_d, eng_proc_q, eng_proc_d, done_q, done_d, err_q, err_d;
  // next-state decision; a finished flag beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ERST;
      ERST:    if (cnt_q == CNT_BITS'(RESET_CYCLES - 1)) state_d = RUN;
      RUN:     if (eng_finished) state_d = DONE;
               else if (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      DONE:    state_d = auto_mode ? ERST : IDLE;
      ERROR:   if (start) state_d = ERST;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs follow the next state so pins lag the decision by one cycle
  always_comb begin
    cnt_d          = (state_d != state_q) ? '0 : cnt_q + CNT_BITS'(1);
    frame_cycles_d = (state_q == RUN && eng_finished) ? cnt_q : frame_cycles_q;
    c_now_d        = (c_up && !c_down && c_now_q != 5'd31) ? c_now_q + 5'd1 :
                     (c_down && !c_up && c_now_q != 5'd0)  ? c_now_q - 5'd1 : c_now_q;
    eng_c_d        = (state_d == ERST && state_q != ERST) ? c_now_q : eng_c_q;
    eng_rst_n_d    = state_d != ERST;
    eng_proc_d     = state_d == RUN;
    done_d         = state_d == DONE;
    err_d          = state_d == ERROR;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_cycles_q <= '0;
      c_now_q        <= 5'(C_INIT);
      eng_c_q        <= 5'(C_INIT);
      eng_rst_n_q    <= 1'b0;
      eng_proc_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_cycles_q <= frame_cycles_d;
      c_now_q        <= c_now_d;
      eng_c_q        <= eng_c_d;
      eng_rst_n_q    <= eng_rst_n_d;
      eng_proc_q     <= eng_proc_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end
  assign img_col        = (state_q == RUN) ? eng_col : disp_col;
  assign img_row        = (state_q == RUN) ? eng_row : disp_row;
  assign disp_stall     = state_q == RUN;
  assign busy           = state_q != IDLE && state_q != ERROR;
  assign eng_rst_n      = eng_rst_n_q;
  assign eng_processing = eng_proc_q;
  assign eng_C          = eng_c_q;
  assign done           = done_q;
  assign err            = err_q;
  assign c_now          = c_now_q;
  assign frame_cycles   = frame_cycles_q;
endmodule
